// File: rtl/spi_port_ctrl.sv
// spi_port_ctrl
//   SPI master (mode 0, MSB first, 8-bit frames) behind the SPI_RANGE CPU window.
//   The CPU sees a byte-wide register file on DATA[15:8]. CPU strobes are asynchronous to
//   MB_CLK. They are synchronised here, and each strobe performs exactly one register access.
//
//   Registers (REG_ADDR):
//     0 DATA    wr: load TX and start a frame (OVR if busy)   rd: RX byte, clears DONE
//     1 STATUS  [7] BUSY [6] DONE [5] OVR; write 1 to bit 6/5 clears that flag
//     2 CTRL    [7:4] DIV (half period = DIV+1 cycles), [0] CS_EN (SPI_CS = ~CS_EN)
//     3 reserved, reads 0x00, writes ignored, still acked
//
// Ports
//   MB_CLK, RESET       system clock (rising edge), asynchronous active-low reset
//   SEL, RW, DS_N       window decode, 1=read, combined data strobe (active-low)
//   REG_ADDR, WDATA     register select, write data from DATA[15:8]
//   RDATA, RD_OE        registered read data, bus drive enable
//   ACK_N               local DTACK (active-low), ANDed into CPU_DTACK at the top level
//   SPI_CS/SCK/MOSI     SPI outputs; SPI_MISO serial input
module spi_port_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  DIV_RESET   = 4'h0
) (
  input  logic       MB_CLK,
  input  logic       RESET,
  input  logic       SEL,
  input  logic       RW,
  input  logic       DS_N,
  input  logic [1:0] REG_ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       RD_OE,
  output logic       ACK_N,
  output logic       SPI_CS,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  // CPU request synchroniser and edge detect
  logic                   req;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_d_q;
  logic                   access;
  logic                   ack_q, ack_d;

  // Register file
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] rd_mux;
  logic [3:0] div_q, div_d;
  logic       cs_en_q, cs_en_d;
  logic [7:0] rx_q, rx_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;

  // Shift engine
  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] frame_div_q, frame_div_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       miso_q, miso_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;

  logic busy;
  logic wr_acc, rd_acc;
  logic start;
  logic frame_done;

  assign req    = SEL & ~DS_N;
  assign req_s  = sync_q[SYNC_STAGES-1];
  assign access = req_s & ~req_d_q;

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q  <= '0;
      req_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req};
      req_d_q <= req_s;
    end
  end

  assign busy   = (state_q != StIdle);
  assign wr_acc = access & ~RW;
  assign rd_acc = access & RW;
  assign start  = wr_acc && (REG_ADDR == AddrData) && !busy;

  // Read data reflects the register values just before the access edge
  always_comb begin
    rd_mux = 8'h00;
    unique case (REG_ADDR)
      AddrData:   rd_mux = rx_q;
      AddrStatus: rd_mux = {busy, done_q, ovr_q, 5'b00000};
      AddrCtrl:   rd_mux = {div_q, 3'b000, cs_en_q};
      default:    rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    frame_div_d = frame_div_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rx_d        = rx_q;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLow;
          shreg_d     = WDATA;
          frame_div_d = div_q;
          cnt_d       = div_q;
          bit_cnt_d   = 3'd0;
          sck_d       = 1'b0;
          mosi_d      = WDATA[7];
        end
      end
      StLow: begin
        if (cnt_q == 4'd0) begin
          state_d = StHigh;
          cnt_d   = frame_div_q;
          sck_d   = 1'b1;
          miso_d  = SPI_MISO;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHigh: begin
        if (cnt_q == 4'd0) begin
          sck_d   = 1'b0;
          cnt_d   = frame_div_q;
          // Sampled bit is held in miso_q until the falling edge so the
          // LSB of TX is still available for transmission.
          shreg_d = {shreg_q[6:0], miso_q};
          if (bit_cnt_q == 3'd7) begin
            state_d    = StIdle;
            rx_d       = {shreg_q[6:0], miso_q};
            frame_done = 1'b1;
          end else begin
            state_d   = StLow;
            mosi_d    = shreg_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = access ? rd_mux : rdata_q;
    ack_d   = access | (ack_q & req_s);
    div_d   = div_q;
    cs_en_d = cs_en_q;
    done_d  = done_q;
    ovr_d   = ovr_q;

    if (rd_acc && (REG_ADDR == AddrData)) begin
      done_d = 1'b0;
    end
    if (wr_acc && (REG_ADDR == AddrStatus)) begin
      if (WDATA[6]) done_d = 1'b0;
      if (WDATA[5]) ovr_d  = 1'b0;
    end
    // DIV is only picked up at frame start, so a write while busy is safe
    if (wr_acc && (REG_ADDR == AddrCtrl)) begin
      div_d   = WDATA[7:4];
      cs_en_d = WDATA[0];
    end
    // Set beats clear when both land on the same edge
    if (wr_acc && (REG_ADDR == AddrData) && busy) begin
      ovr_d = 1'b1;
    end
    if (frame_done) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      shreg_q     <= 8'h00;
      frame_div_q <= 4'h0;
      cnt_q       <= 4'h0;
      bit_cnt_q   <= 3'd0;
      miso_q      <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rx_q        <= 8'h00;
      rdata_q     <= 8'h00;
      ack_q       <= 1'b0;
      div_q       <= DIV_RESET;
      cs_en_q     <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      frame_div_q <= frame_div_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      div_q       <= div_d;
      cs_en_q     <= cs_en_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign RDATA    = rdata_q;
  assign RD_OE    = SEL & RW & ~DS_N;
  // SEL gating releases the ack as soon as the CPU ends its cycle
  assign ACK_N    = ~(ack_q & SEL);
  assign SPI_CS   = ~cs_en_q;
  assign SPI_SCK  = sck_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_port_ctrl.sv
// tb_spi_port_ctrl
//   Directed bench for spi_port_ctrl: reset state, register access handshake, frame timing
//   at two divider settings, overrun, asynchronous reset mid-frame, and ack behaviour.
module tb_spi_port_ctrl;

  localparam logic [3:0] DivRst = 4'h5;

  logic       MB_CLK = 1'b0;
  logic       RESET;
  logic       SEL;
  logic       RW;
  logic       DS_N;
  logic [1:0] REG_ADDR;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic       RD_OE;
  logic       ACK_N;
  logic       SPI_CS;
  logic       SPI_SCK;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       loop_en;

  assign SPI_MISO = loop_en ? SPI_MOSI : 1'b0;

  spi_port_ctrl #(
    .SYNC_STAGES(2),
    .DIV_RESET  (DivRst)
  ) dut (
    .MB_CLK  (MB_CLK),
    .RESET   (RESET),
    .SEL     (SEL),
    .RW      (RW),
    .DS_N    (DS_N),
    .REG_ADDR(REG_ADDR),
    .WDATA   (WDATA),
    .RDATA   (RDATA),
    .RD_OE   (RD_OE),
    .ACK_N   (ACK_N),
    .SPI_CS  (SPI_CS),
    .SPI_SCK (SPI_SCK),
    .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO)
  );

  always #5 MB_CLK = ~MB_CLK;

  int cyc = 0;
  always @(posedge MB_CLK) cyc <= cyc + 1;

  // SCK edge capture, sampled on the falling MB_CLK edge
  logic sck_prev = 1'b0;
  int   rise_cyc[$];
  logic rise_mosi[$];
  int   fall_cyc[$];

  always @(negedge MB_CLK) begin
    if (SPI_SCK && !sck_prev) begin
      rise_cyc.push_back(cyc);
      rise_mosi.push_back(SPI_MOSI);
    end
    if (!SPI_SCK && sck_prev) fall_cyc.push_back(cyc);
    sck_prev = SPI_SCK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_capture();
    rise_cyc.delete();
    rise_mosi.delete();
    fall_cyc.delete();
  endtask

  function automatic logic [7:0] mosi_byte();
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8 && i < rise_mosi.size(); i++) b = {b[6:0], rise_mosi[i]};
    return b;
  endfunction

  // One CPU cycle; t_acc is the MB_CLK edge count at which the access should land
  task automatic cpu_access(input logic rw, input logic [1:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd, output int t_acc);
    int n;
    @(negedge MB_CLK);
    SEL = 1'b1; RW = rw; REG_ADDR = addr; WDATA = wd; DS_N = 1'b0;
    t_acc = cyc + 3;
    n = 0;
    while (ACK_N && n < 20) begin
      @(negedge MB_CLK);
      n++;
    end
    check_eq("ack_seen", {31'd0, ACK_N}, 32'd0);
    rd = RDATA;
    SEL = 1'b0; DS_N = 1'b1; RW = 1'b1;
    repeat (4) @(negedge MB_CLK);
  endtask

  task automatic reg_wr(input logic [1:0] addr, input logic [7:0] wd, output int t_acc);
    logic [7:0] dummy;
    cpu_access(1'b0, addr, wd, dummy, t_acc);
  endtask

  task automatic reg_rd(input logic [1:0] addr, output logic [7:0] rd);
    int dummy;
    cpu_access(1'b1, addr, 8'h00, rd, dummy);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge MB_CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    int t0, t1, n, lows;

    RESET = 1'b0; SEL = 1'b0; RW = 1'b1; DS_N = 1'b1; REG_ADDR = 2'd0; WDATA = 8'h00;
    loop_en = 1'b1;

    // 1: reset state
    wait_cycles(3);
    check_eq("rst_cs", {31'd0, SPI_CS}, 32'd1);
    check_eq("rst_sck", {31'd0, SPI_SCK}, 32'd0);
    check_eq("rst_mosi", {31'd0, SPI_MOSI}, 32'd0);
    check_eq("rst_ack_n", {31'd0, ACK_N}, 32'd1);
    check_eq("rst_rdata", {24'd0, RDATA}, 32'h00);
    RESET = 1'b1;
    wait_cycles(2);
    reg_rd(2'd1, rd); check_eq("rst_status", {24'd0, rd}, 32'h00);
    reg_rd(2'd2, rd); check_eq("rst_ctrl", {24'd0, rd}, {24'd0, DivRst, 4'h0});

    // 2: DIV=0 loopback frame 0xA5
    reg_wr(2'd2, 8'h01, t0);
    check_eq("t2_cs_low", {31'd0, SPI_CS}, 32'd0);
    clear_capture();
    reg_wr(2'd0, 8'hA5, t0);
    wait_cycles(20);
    check_eq("t2_rises", rise_cyc.size(), 8);
    check_eq("t2_mosi", {24'd0, mosi_byte()}, 32'hA5);
    if (rise_cyc.size() == 8 && fall_cyc.size() == 8) begin
      check_eq("t2_first_rise", rise_cyc[0], t0 + 1);
      check_eq("t2_rise_span", rise_cyc[7] - rise_cyc[0], 14);
      check_eq("t2_last_fall", fall_cyc[7], t0 + 16);
    end else begin
      check_eq("t2_edge_count", fall_cyc.size(), 8);
    end
    reg_rd(2'd1, rd); check_eq("t2_status_done", {24'd0, rd}, 32'h40);
    reg_rd(2'd0, rd); check_eq("t2_rx", {24'd0, rd}, 32'hA5);
    reg_rd(2'd1, rd); check_eq("t2_status_clr", {24'd0, rd}, 32'h00);

    // 3: DIV=3, MISO tied low, frame 0x3C
    loop_en = 1'b0;
    reg_wr(2'd2, 8'h31, t0);
    clear_capture();
    reg_wr(2'd0, 8'h3C, t0);
    reg_rd(2'd1, rd); check_eq("t3_status_busy", {24'd0, rd}, 32'h80);
    wait_cycles(70);
    check_eq("t3_rises", rise_cyc.size(), 8);
    check_eq("t3_mosi", {24'd0, mosi_byte()}, 32'h3C);
    if (rise_cyc.size() == 8 && fall_cyc.size() == 8) begin
      check_eq("t3_first_rise", rise_cyc[0], t0 + 4);
      check_eq("t3_high_len", fall_cyc[0] - rise_cyc[0], 4);
      check_eq("t3_rise_span", rise_cyc[7] - rise_cyc[0], 56);
      check_eq("t3_last_fall", fall_cyc[7], t0 + 64);
    end else begin
      check_eq("t3_edge_count", fall_cyc.size(), 8);
    end
    reg_rd(2'd1, rd); check_eq("t3_status_done", {24'd0, rd}, 32'h40);
    reg_rd(2'd0, rd); check_eq("t3_rx", {24'd0, rd}, 32'h00);

    // 4: overrun during a frame
    loop_en = 1'b1;
    clear_capture();
    reg_wr(2'd0, 8'h5A, t0);
    reg_rd(2'd0, rd); check_eq("t4_rx_prev", {24'd0, rd}, 32'h00);
    reg_wr(2'd0, 8'h11, t1);
    reg_rd(2'd1, rd); check_eq("t4_status_ovr", {24'd0, rd}, 32'hA0);
    wait_cycles(70);
    check_eq("t4_mosi", {24'd0, mosi_byte()}, 32'h5A);
    reg_rd(2'd1, rd); check_eq("t4_status_end", {24'd0, rd}, 32'h60);
    reg_wr(2'd1, 8'h20, t1);
    reg_rd(2'd1, rd); check_eq("t4_ovr_clr", {24'd0, rd}, 32'h40);
    reg_rd(2'd0, rd); check_eq("t4_rx", {24'd0, rd}, 32'h5A);
    reg_rd(2'd1, rd); check_eq("t4_status_idle", {24'd0, rd}, 32'h00);

    // 5: asynchronous reset mid-frame
    clear_capture();
    reg_wr(2'd0, 8'hFF, t0);
    n = 0;
    while (rise_cyc.size() < 4 && n < 200) begin
      @(negedge MB_CLK);
      n++;
    end
    check_eq("t5_reached_bit4", {31'd0, rise_cyc.size() >= 4}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    check_eq("t5_sck", {31'd0, SPI_SCK}, 32'd0);
    check_eq("t5_cs", {31'd0, SPI_CS}, 32'd1);
    check_eq("t5_mosi", {31'd0, SPI_MOSI}, 32'd0);
    wait_cycles(2);
    RESET = 1'b1;
    wait_cycles(2);
    reg_rd(2'd1, rd); check_eq("t5_status", {24'd0, rd}, 32'h00);
    reg_rd(2'd2, rd); check_eq("t5_ctrl", {24'd0, rd}, {24'd0, DivRst, 4'h0});
    reg_wr(2'd2, 8'h01, t1);
    clear_capture();
    reg_wr(2'd0, 8'h96, t0);
    wait_cycles(20);
    check_eq("t5_mosi_next", {24'd0, mosi_byte()}, 32'h96);
    if (fall_cyc.size() == 8) check_eq("t5_last_fall", fall_cyc[7], t0 + 16);
    else check_eq("t5_fall_count", fall_cyc.size(), 8);
    reg_rd(2'd0, rd); check_eq("t5_rx", {24'd0, rd}, 32'h96);

    // 6: ack handshake details
    clear_capture();
    @(negedge MB_CLK);
    SEL = 1'b1; RW = 1'b0; REG_ADDR = 2'd0; WDATA = 8'h42; DS_N = 1'b1;
    lows = 0;
    repeat (10) begin
      @(negedge MB_CLK);
      if (!ACK_N) lows++;
    end
    check_eq("t6_no_ds_ack", lows, 0);
    check_eq("t6_no_ds_access", rise_cyc.size(), 0);
    DS_N = 1'b0;
    n = 0;
    while (ACK_N && n < 20) begin
      @(negedge MB_CLK);
      n++;
    end
    check_eq("t6_ack_latency", n, 3);
    lows = 0;
    repeat (30) begin
      @(negedge MB_CLK);
      if (!ACK_N) lows++;
    end
    check_eq("t6_ack_held", lows, 30);
    #2 SEL = 1'b0;
    #1 check_eq("t6_ack_release", {31'd0, ACK_N}, 32'd1);
    DS_N = 1'b1; RW = 1'b1;
    wait_cycles(5);
    check_eq("t6_one_frame", rise_cyc.size(), 8);
    reg_rd(2'd1, rd); check_eq("t6_status", {24'd0, rd}, 32'h40);
    reg_rd(2'd0, rd); check_eq("t6_rx", {24'd0, rd}, 32'h42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
